// File: rtl/ddr3_port_arbiter_if.sv
// Request/response bundle between a requester and a memory port.
// ID_W is 15 on the requester side and 16 on the core side, where the port index is added.
interface ddr3_port_arbiter_if #(
   parameter int ID_W = 15
);
   logic [15:0]     wr;
   logic            rd;
   logic [31:0]     addr;
   logic [127:0]    write_data;
   logic [ID_W-1:0] req_id;
   logic            accept;
   logic            ack;
   logic            error;
   logic [ID_W-1:0] resp_id;
   logic [127:0]    read_data;

   modport master (
      output wr, rd, addr, write_data, req_id,
      input  accept, ack, error, resp_id, read_data
   );

   modport slave (
      input  wr, rd, addr, write_data, req_id,
      output accept, ack, error, resp_id, read_data
   );
endinterface

// File: rtl/ddr3_port_arbiter.sv
// Round-robin arbiter sharing one registered ddr3_core request port between two requesters.
// Each port has an outstanding-request limit, and responses are steered back using bit 15 of the response ID.
module ddr3_port_arbiter #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   ddr3_port_arbiter_if.slave  port0,
   ddr3_port_arbiter_if.slave  port1,
   ddr3_port_arbiter_if.master core
);
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

   state_t          state_q, state_d;
   logic            prio_q;
   logic [1:0][3:0] cnt_q, cnt_d;
   logic [1:0]      pending, eligible, inc, dec, accept;
   logic            load, grant, winner;

   logic [15:0]     wr_q, sel_wr;
   logic            rd_q, sel_rd;
   logic [31:0]     addr_q, sel_addr;
   logic [127:0]    data_q, sel_data;
   logic [15:0]     id_q, sel_id;

   assign pending[0] = (|port0.wr) | port0.rd;
   assign pending[1] = (|port1.wr) | port1.rd;
   assign inc[0] = (state_q == BUSY) && core.accept && !id_q[15];
   assign inc[1] = (state_q == BUSY) && core.accept &&  id_q[15];
   assign dec[0] = core.ack && !core.resp_id[15];
   assign dec[1] = core.ack &&  core.resp_id[15];

   // Eligibility looks at next-cycle counts, so an ack can free a slot in the same cycle.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         // NOTE: default every comb output first so no path leaves it unassigned (latch).
         cnt_d[i] = cnt_q[i];
         if (inc[i] && !dec[i] && cnt_q[i] < MAX_CNT)
            cnt_d[i] = cnt_q[i] + 4'd1;
         else if (dec[i] && !inc[i] && cnt_q[i] != 4'd0)
            cnt_d[i] = cnt_q[i] - 4'd1;
         eligible[i] = pending[i] && (cnt_d[i] < MAX_CNT);
      end
   end

   assign sel_wr   = winner ? port1.wr         : port0.wr;
   assign sel_rd   = winner ? port1.rd         : port0.rd;
   assign sel_addr = winner ? port1.addr       : port0.addr;
   assign sel_data = winner ? port1.write_data : port0.write_data;
   assign sel_id   = {winner, (winner ? port1.req_id : port0.req_id)};

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state.
   always_comb begin
      state_d = state_q;
      if (load) state_d = grant ? BUSY : IDLE;
   end

   // Outputs: load decision, winner and the combinational accepts.
   always_comb begin
      load   = (state_q == IDLE) || core.accept;
      grant  = load && (|eligible);
      winner = (eligible[0] && eligible[1]) ? prio_q : eligible[1];
      accept = '0;
      if (grant && rst_i) accept[winner] = 1'b1;
   end

   // NOTE: the request register is reset, not just its valid bits, because core_* must read 0 in reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         prio_q <= 1'b0;
         cnt_q  <= '0;
         wr_q   <= '0;
         rd_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         id_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (grant) begin
            wr_q   <= sel_wr;
            rd_q   <= sel_rd;
            addr_q <= sel_addr;
            data_q <= sel_data;
            id_q   <= sel_id;
            prio_q <= ~winner;
         end else if (load) begin
            wr_q <= '0;
            rd_q <= 1'b0;
         end
      end
   end

   assign core.wr         = wr_q;
   assign core.rd         = rd_q;
   assign core.addr       = addr_q;
   assign core.write_data = data_q;
   assign core.req_id     = id_q;

   assign port0.accept    = accept[0];
   assign port1.accept    = accept[1];
   assign port0.ack       = core.ack && !core.resp_id[15];
   assign port1.ack       = core.ack &&  core.resp_id[15];
   assign port0.resp_id   = core.resp_id[14:0];
   assign port1.resp_id   = core.resp_id[14:0];
   assign port0.error     = core.error;
   assign port1.error     = core.error;
   assign port0.read_data = core.read_data;
   assign port1.read_data = core.read_data;
endmodule
